// File: rtl/ws2812b_frame_ctrl.sv
// ws2812b_frame_ctrl: GRB frame buffer streamed as 3-phase WS2812B symbols; define WS2812B_AUTO_REFRESH_EN for continuous refresh.
module ws2812b_frame_ctrl #(
  parameter int TICKS_PER_PHASE = 11,
  parameter int PIXEL_CNT = 12,
  parameter int ADDR_W = 4,
  parameter int LATCH_PHASES = 720
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pixel_pin
);
  localparam int TW = $clog2(TICKS_PER_PHASE);
  localparam int PW = PIXEL_CNT > 1 ? $clog2(PIXEL_CNT) : 1;
  localparam int LW = $clog2(LATCH_PHASES + 1);
  // pixel_pin is registered, so the gap is counted one cycle past the line's view of it
`ifdef WS2812B_AUTO_REFRESH_EN
  localparam logic AUTO = 1'b1;
  localparam int LAT_P = LATCH_PHASES - 1;
  localparam int LAT_T = TICKS_PER_PHASE - 2;
`else
  localparam logic AUTO = 1'b0;
  localparam int LAT_P = LATCH_PHASES;
  localparam int LAT_T = 0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t state, state_n;
  logic [23:0] mem [2**ADDR_W];
  logic [23:0] shreg;
  logic [TW-1:0] tick;
  logic [1:0] ph;
  logic [4:0] bit_i;
  logic [PW-1:0] px;
  logic [LW-1:0] lph;
  logic tick_end, bit_end, pix_end, frame_end, latch_end, start_ok;

  assign tick_end = tick == TW'(TICKS_PER_PHASE - 1);
  assign bit_end = tick_end && ph == 2'd2;
  assign pix_end = bit_end && bit_i == 5'd23;
  assign frame_end = pix_end && px == PW'(PIXEL_CNT - 1);
  assign latch_end = state == LATCH && lph == LW'(LAT_P) && tick == TW'(LAT_T);
  assign start_ok = start && !busy && !done;

  always_ff @(posedge sys_clk)
    if (wr_en && 32'(wr_addr) < PIXEL_CNT) mem[wr_addr] <= wr_data;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start_ok) state_n = LOAD;
      LOAD:  state_n = SEND;
      SEND:  if (frame_end) state_n = LATCH;
      LATCH: if (latch_end) state_n = AUTO ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pixel_pin <= 1'b0;
      tick <= '0;
      ph <= '0;
      bit_i <= '0;
      px <= '0;
      lph <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      done <= latch_end;
      pixel_pin <= state == SEND && (ph == 2'd0 || (ph == 2'd1 && shreg[23]));
      tick <= (state == SEND || state == LATCH) && !tick_end ? tick + 1'b1 : '0;
      lph <= state == LATCH ? lph + LW'(tick_end) : '0;
      if (state == LOAD) begin
        ph <= '0;
        bit_i <= '0;
        px <= '0;
        shreg <= mem[0];
      end else if (state == SEND && tick_end) begin
        ph <= ph == 2'd2 ? 2'd0 : ph + 1'b1;
        if (bit_end) begin
          bit_i <= bit_i == 5'd23 ? 5'd0 : bit_i + 1'b1;
          // next pixel is fetched at the end of bit 0 so pixels abut with no gap
          shreg <= pix_end && !frame_end ? mem[ADDR_W'(px + 1'b1)] : shreg << 1;
          if (pix_end && !frame_end) px <= px + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// tb_ws2812b_frame_ctrl: randomized frames checked every cycle against a timeline model of the WS2812B line.
module tb_ws2812b_frame_ctrl;
  localparam int TPP = 4, PC = 2, AW = 1, LP = 8;
  localparam int SYM = 3 * TPP, PIX_CYC = 24 * SYM, SEND_CYC = PC * PIX_CYC;
  localparam int FRAME = SEND_CYC + LP * TPP, DONE_N = FRAME + 2;
`ifdef WS2812B_AUTO_REFRESH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int U1_DONE = AUTO ? 24 * SYM + LP * TPP : 24 * SYM + LP * TPP + 2;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, wr_en = 1'b0, start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic busy, done, pixel_pin;
  logic wr_en1 = 1'b0, start1 = 1'b0;
  logic [0:0] wr_addr1 = '0;
  logic [23:0] wr_data1 = '0;
  logic busy1, done1, pin1;

  ws2812b_frame_ctrl #(.TICKS_PER_PHASE(TPP), .PIXEL_CNT(PC), .ADDR_W(AW), .LATCH_PHASES(LP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .pixel_pin(pixel_pin));

  ws2812b_frame_ctrl #(.TICKS_PER_PHASE(TPP), .PIXEL_CNT(1), .ADDR_W(1), .LATCH_PHASES(LP)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .busy(busy1), .done(done1), .pixel_pin(pin1));

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: n counts edges since the edge that accepted start; pixel p is captured on edge 1+p*PIX_CYC
  logic [23:0] mb [PC];
  logic [23:0] snap [PC];
  logic pin_log [0:DONE_N];
  bit active = 1'b0;
  int n = 0, frames = 0, done_at = -1, done_cnt = 0;

  function automatic logic exp_pin();
    int k, p, b, ph;
    if (!active || n < 2 || n >= 2 + SEND_CYC) return 1'b0;
    k = n - 2;
    p = k / PIX_CYC;
    b = (k % PIX_CYC) / SYM;
    ph = (k % SYM) / TPP;
    return ph == 0 ? 1'b1 : ph == 1 ? snap[p][23-b] : 1'b0;
  endfunction

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      active = 1'b0;
      n = 0;
      frames = 0;
    end else if (active && !AUTO && n == DONE_N) active = 1'b0;
    else if (active) begin
      n = n + 1;
      if (AUTO && n == FRAME) begin
        n = 0;
        frames++;
      end
    end else if (start) begin
      active = 1'b1;
      n = 0;
      frames = 0;
    end
    for (int p = 0; p < PC; p++)
      if (active && n == 1 + p * PIX_CYC) snap[p] = mb[p];
    if (wr_en && int'(wr_addr) < PC) mb[wr_addr] = wr_data;
    #1;
    chk("pixel_pin", pixel_pin, exp_pin());
    chk("busy", busy, active && (AUTO || n < DONE_N));
    chk("done", done, active && (AUTO ? (n == 0 && frames > 0) : n == DONE_N));
    if (active) pin_log[n] = pixel_pin;
    if (done) begin
      done_at = n;
      done_cnt++;
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(negedge sys_clk);
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < DONE_N + 50) begin
      tick();
      t++;
    end
    chk(name, done, 1'b1);
  endtask

  function automatic logic [23:0] rd_pix(input int p);
    logic [23:0] v;
    for (int b = 0; b < 24; b++) v[23-b] = pin_log[2 + p * PIX_CYC + b * SYM + TPP];
    return v;
  endfunction

  task automatic lit_basic();
    chk("bit0_p1", pin_log[2 + TPP], 1'b1);
    chk("bit7_p1_end", pin_log[2 + 7 * SYM + 2 * TPP - 1], 1'b1);
    chk("bit7_p2", pin_log[2 + 7 * SYM + 2 * TPP], 1'b0);
    chk("bit8_p0_end", pin_log[2 + 8 * SYM + TPP - 1], 1'b1);
    chk("bit8_p1", pin_log[2 + 8 * SYM + TPP], 1'b0);
    chk("bit47_p1_end", pin_log[2 + 47 * SYM + 2 * TPP - 1], 1'b1);
    chk("bit47_p2", pin_log[2 + 47 * SYM + 2 * TPP], 1'b0);
    chk("gap_start", pin_log[2 + SEND_CYC], 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int t, ones;
    logic [23:0] v;
    logic log1 [0:400];
    int d1;
    tick(3);
    chk("rst_pin", pixel_pin, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    sys_rst_n = 1'b1;
    tick(2);
    wr(0, 24'hFF0000);
    wr(1, 24'h000001);
    go();
    chk("busy_after_start", busy, 1'b1);
    tick();
    chk("pin_n1_low", pixel_pin, 1'b0);
    tick();
    chk("pin_rise_n2", pixel_pin, 1'b1);
`ifdef WS2812B_AUTO_REFRESH_EN
    done_cnt = 0;
    tick(3 * FRAME + 10);
    lit_basic();
    chk("auto_done_count", done_cnt, 3);
    chk("auto_busy", busy, 1'b1);
`else
    wait_done("basic_done");
    chk("done_edge", done_at, DONE_N);
    chk("busy_low_at_done", busy, 1'b0);
    lit_basic();
    tick();
    chk("done_one_cycle", done, 1'b0);
    wr(0, 24'h123456);
    wr(1, 24'h000000);
    go();
    tick(40);
    wr(1, 24'hFFFFFF);
    wr(0, 24'h000000);
    wait_done("wdf_done");
    ones = 0;
    for (int b = 0; b < 24; b++) ones += int'(pin_log[2 + PIX_CYC + b * SYM + TPP]);
    chk("pix1_all_ones", ones, 24);
    chk("pix0_unchanged", rd_pix(0), 24'h123456);
    wr(0, $urandom());
    wr(1, $urandom());
    go();
    tick(100);
    go();
    wait_done("busy_start_done");
    go();
    chk("start_on_done_ignored", busy, 1'b0);
    tick(20);
    chk("no_second_frame", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wr(0, $urandom());
      wr(1, $urandom());
      go();
      t = 0;
      while (!done && t < DONE_N + 50) begin
        wr_en = $urandom_range(0, 15) == 0;
        wr_addr = AW'($urandom_range(0, 1));
        wr_data = $urandom();
        start = $urandom_range(0, 40) == 0;
        tick();
        t++;
      end
      wr_en = 1'b0;
      start = 1'b0;
      chk("rand_done", done, 1'b1);
      tick($urandom_range(1, 5));
    end
    wr(0, 24'hFF0000);
    wr(1, 24'h000000);
    go();
    tick(3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_pin", pixel_pin, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);
    go();
    wait_done("post_rst_done");
    chk("buffer_survives_rst", rd_pix(0), 24'hFF0000);
`endif
    wr_en1 = 1'b1;
    wr_addr1 = 1'b0;
    wr_data1 = 24'hA5A5A5;
    tick();
    wr_addr1 = 1'b1;
    wr_data1 = 24'hFFFFFF;
    tick();
    wr_en1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    d1 = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      log1[k] = pin1;
      if (done1 && d1 < 0) d1 = k;
    end
    for (int b = 0; b < 24; b++) v[23-b] = log1[2 + b * SYM + TPP];
    chk("u1_pixel", v, 24'hA5A5A5);
    chk("u1_done_edge", d1, U1_DONE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ws2812b_frame_ctrl.md
Name: ws2812b_frame_ctrl

Overview:
- Frame controller for a WS2812B chain, running on the single system clock.
- Owns a PIXEL_CNT-deep GRB frame buffer with a host write port.
- On a start request it streams the whole frame as 3-phase 1-bit-symbols on pixel_pin, then holds the line low for a latch gap.
- Bit timing comes from clock-enable phase ticks, not derived clocks. It replaces the divided-clock word sequencers as the single scheduler between pattern generators and the LED pin.

Parameters:
- TICKS_PER_PHASE, 11: sys_clk cycles per symbol phase (27 MHz / 11 ≈ 2.45 MHz phase rate); legal range ≥2.
- PIXEL_CNT, 12: number of LEDs in the chain and frame buffer depth; legal range ≥1.
- ADDR_W, 4: width of wr_addr; must satisfy 2^ADDR_W ≥ PIXEL_CNT.
- LATCH_PHASES, 720: low phases after the last bit (≈300 us); legal range ≥1.

Ports:
- sys_clk  input  1  system clock; all logic on posedge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  frame buffer write strobe.
- wr_addr  input  ADDR_W  pixel index to write.
- wr_data  input  24  pixel in GRB order; bit 23 = g7 is transmitted first.
- start  input  1  request one frame transmission.
- busy  output  1  high while a frame or its latch gap is in progress.
- done  output  1  one-cycle pulse at the end of each frame's latch gap.
- pixel_pin  output  1  serial data line to the first LED.

Behaviour:
- Reset (asynchronous, immediate):
  - pixel_pin=0, busy=0, done=0, state=IDLE; phase, bit and pixel counters cleared.
  - Frame buffer contents are not cleared and survive reset; power-up value is all zero.
- Writes:
  - wr_en with wr_addr<PIXEL_CNT writes wr_data in one cycle, in any state.
  - wr_addr≥PIXEL_CNT is ignored.
  - A write to a pixel already loaded into the shift register does not affect the frame in flight.
  - A write to a not-yet-loaded pixel appears in the current frame.
- State machine IDLE → LOAD → SEND → LATCH → IDLE:
  - IDLE: pixel_pin=0. start=1 moves to LOAD on the next edge; busy=1 from that edge.
  - LOAD (1 cycle): registered read of pixel 0 into a 24-bit shift register; phase counter cleared.
  - SEND: phase_tick fires every TICKS_PER_PHASE cycles. Each bit is 3 phases with pixel_pin = 1, then bit value, then 0.
    - Ordering is MSB first, pixel 0 first.
    - pixel_pin first rises 2 cycles after the edge that samples start.
    - The next pixel is read during the final phase of the current pixel's bit 0, so there are no gaps between pixels.
    - After the 3rd phase of bit 0 of pixel PIXEL_CNT-1, go to LATCH.
  - LATCH: pixel_pin=0 for LATCH_PHASES phases. Then done=1 for one cycle, busy=0 in that same cycle, and go to IDLE.
- start is ignored while busy=1, and on the cycle done=1.
- Frame length is exactly PIXEL_CNT*72*TICKS_PER_PHASE + LATCH_PHASES*TICKS_PER_PHASE cycles.
- Counter widths are sized with $clog2 of their maxima; no wrap is allowed within a frame.

Optional Feature:
- Macro: WS2812B_AUTO_REFRESH_EN.
- When defined:
  - After LATCH, go directly to LOAD instead of IDLE.
  - busy stays 1 continuously after the first start.
  - done pulses once per frame.
  - start is only needed once after reset.
- When undefined: single-shot behaviour exactly as described under Behaviour.

Test Plan (TICKS_PER_PHASE=4, PIXEL_CNT=2, ADDR_W=1, LATCH_PHASES=8 unless stated):
- Reset values: hold sys_rst_n=0 → pixel_pin=0, busy=0, done=0.
- Basic frame: write pix0=0xFF0000 and pix1=0x000001, then start at edge 0.
  - busy=1 at edge 1; pixel_pin rises at edge 2.
  - Each of the first 8 bits is high 8 cycles then low 4.
  - Bits 8–46 are high 4 then low 8; the final bit is high 8 then low 4.
  - done pulses at edge 610 (2+576+32); busy=0 at edge 610.
- Write during frame: write pix1=0xFFFFFF while pix0 is shifting → all 24 bits of pix1 transmit as '1'. Writing pix0 mid-pix0 leaves pix0 unchanged. Write to wr_addr=1 with PIXEL_CNT=1 build is ignored.
- Start while busy: pulse start mid-SEND and on the done cycle → no second frame; busy=0 after done.
- Reset mid-operation: assert sys_rst_n=0 during a high phase → pixel_pin=0 asynchronously, busy=0. Buffer still reads 0xFF0000 in the next frame.
- Auto-refresh (macro defined): single start → done pulses every 608 cycles, busy never drops, waveforms identical to the basic frame.
